// File: rtl/cfg_pkg.sv
// Shared definitions for the config loader: default sizes, FSM state type
// and a small sizing helper used to dimension the phase counter.
package cfg_pkg;

    localparam int unsigned CFG_DATA_W    = 32;
    localparam int unsigned CFG_NUM_WORDS = 36;
    localparam int unsigned CFG_IDX_W     = $clog2(CFG_NUM_WORDS);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SHIFT  = 3'd1,
        SETUP  = 3'd2,
        STROBE = 3'd3,
        HOLD   = 3'd4,
        DONE   = 3'd5
    } cfg_state_t;

    // Largest of the three phase lengths; sizes the shared phase counter.
    function automatic int unsigned cfg_max3(input int unsigned a,
                                             input int unsigned b,
                                             input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/cfg_deserializer.sv
// Bit-serial to parallel word assembler, LSB of each word first.
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   i_clear         restart bit counting at bit 0 (new load)
//   i_bit           serial data bit
//   i_transfer      i_bit is accepted this cycle
//   o_word_c        assembled word including the bit accepted this cycle
//   o_word_valid_c  this transfer completes a word
module cfg_deserializer
    import cfg_pkg::*;
#(
    parameter int unsigned DATA_W = CFG_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_clear,
    input  logic              i_bit,
    input  logic              i_transfer,
    output logic [DATA_W-1:0] o_word_c,
    output logic              o_word_valid_c
);

    localparam int unsigned CNT_W = $clog2(DATA_W);

    logic [DATA_W-1:0] r_shreg;
    logic [CNT_W-1:0]  r_bitcnt;
    logic              w_last;

    assign w_last = (r_bitcnt == CNT_W'(DATA_W - 1));

    // Shift register and bit counter; the counter wraps on the final bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_shreg  <= '0;
            r_bitcnt <= '0;
        end else if (i_clear) begin
            r_bitcnt <= '0;
        end else if (i_transfer) begin
            r_shreg[r_bitcnt] <= i_bit;
            r_bitcnt          <= w_last ? '0 : r_bitcnt + CNT_W'(1);
        end
    end

    // Merge the in-flight bit so the full word is available on the last transfer.
    always_comb begin
        o_word_c           = r_shreg;
        o_word_c[r_bitcnt] = i_bit;
    end

    assign o_word_valid_c = i_transfer & w_last;

endmodule

// File: rtl/configs_loader.sv
// Config stream loader: deserialises a serial config stream and writes each
// word into the latch bank with a registered one-hot enable, bracketed by
// setup and hold phases. One pass over all words per io_start.
// Ports:
//   clk, reset     clock, synchronous active-high reset
//   io_start       begin a full load (honoured only in IDLE/DONE)
//   io_cfg_bit     serial config data, LSB first
//   io_cfg_valid   io_cfg_bit valid
//   io_cfg_ready   loader accepts a bit (only in SHIFT)
//   io_d_out       word presented to the latch bank
//   io_configs_en  one-hot latch enable
//   io_word_idx    index of the word in progress
//   io_busy        load in progress
//   io_done        sticky load-complete flag
module configs_loader
    import cfg_pkg::*;
#(
    parameter  int unsigned DATA_W     = CFG_DATA_W,
    parameter  int unsigned NUM_WORDS  = CFG_NUM_WORDS,
    parameter  int unsigned SETUP_CYC  = 1,
    parameter  int unsigned STROBE_CYC = 1,
    parameter  int unsigned HOLD_CYC   = 1,
    localparam int unsigned IDX_W      = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 io_start,
    input  logic                 io_cfg_bit,
    input  logic                 io_cfg_valid,
    output logic                 io_cfg_ready,
    output logic [DATA_W-1:0]    io_d_out,
    output logic [NUM_WORDS-1:0] io_configs_en,
    output logic [IDX_W-1:0]     io_word_idx,
    output logic                 io_busy,
    output logic                 io_done
);

    localparam int unsigned PH_MAX = cfg_max3(SETUP_CYC, STROBE_CYC, HOLD_CYC);
    localparam int unsigned PH_W   = $clog2(PH_MAX + 1);

    cfg_state_t          r_state;
    cfg_state_t          w_state_nxt;
    logic [PH_W-1:0]     r_phase;
    logic [PH_W-1:0]     w_phase_nxt;
    logic [IDX_W-1:0]    r_idx;
    logic [IDX_W-1:0]    w_idx_nxt;
    logic [DATA_W-1:0]   r_d_out;
    logic [DATA_W-1:0]   w_d_out_nxt;
    logic [NUM_WORDS-1:0] r_en;
    logic [NUM_WORDS-1:0] w_en_nxt;
    logic                r_cfg_ready;
    logic                w_cfg_ready_nxt;
    logic                r_busy;
    logic                w_busy_nxt;
    logic                r_done;
    logic                w_done_nxt;

    logic                w_start;
    logic                w_transfer;
    logic                w_phase_last;
    logic                w_idx_last;
    logic [DATA_W-1:0]   w_word;
    logic                w_word_valid;

    assign w_start    = io_start & ((r_state == IDLE) | (r_state == DONE));
    assign w_transfer = io_cfg_valid & r_cfg_ready;
    assign w_idx_last = (r_idx == IDX_W'(NUM_WORDS - 1));

    cfg_deserializer #(
        .DATA_W (DATA_W)
    ) u_deser (
        .clk            (clk),
        .reset          (reset),
        .i_clear        (w_start),
        .i_bit          (io_cfg_bit),
        .i_transfer     (w_transfer),
        .o_word_c       (w_word),
        .o_word_valid_c (w_word_valid)
    );

    // Final cycle of the current timed phase.
    always_comb begin
        w_phase_last = 1'b0;
        case (r_state)
            SETUP:   w_phase_last = (r_phase == PH_W'(SETUP_CYC - 1));
            STROBE:  w_phase_last = (r_phase == PH_W'(STROBE_CYC - 1));
            HOLD:    w_phase_last = (r_phase == PH_W'(HOLD_CYC - 1));
            default: w_phase_last = 1'b0;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_start) w_state_nxt = SHIFT;
            SHIFT:   if (w_word_valid) w_state_nxt = SETUP;
            SETUP:   if (w_phase_last) w_state_nxt = STROBE;
            STROBE:  if (w_phase_last) w_state_nxt = HOLD;
            HOLD:    if (w_phase_last) w_state_nxt = w_idx_last ? DONE : SHIFT;
            DONE:    if (w_start) w_state_nxt = SHIFT;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Next values for every registered output and datapath register.
    always_comb begin
        w_phase_nxt     = '0;
        w_idx_nxt       = r_idx;
        w_d_out_nxt     = r_d_out;
        w_en_nxt        = '0;
        w_cfg_ready_nxt = (w_state_nxt == SHIFT);
        w_busy_nxt      = (w_state_nxt != IDLE) && (w_state_nxt != DONE);
        w_done_nxt      = r_done;

        if ((r_state == SETUP || r_state == STROBE || r_state == HOLD) && !w_phase_last) begin
            w_phase_nxt = r_phase + PH_W'(1);
        end

        if (w_start) begin
            w_idx_nxt  = '0;
            w_done_nxt = 1'b0;
        end else if (r_state == HOLD && w_phase_last) begin
            if (w_idx_last) begin
                w_done_nxt = 1'b1;
            end else begin
                w_idx_nxt = r_idx + IDX_W'(1);
            end
        end

        // Word is captured only on the SHIFT->SETUP edge.
        if (r_state == SHIFT && w_word_valid) begin
            w_d_out_nxt = w_word;
        end

        // Enable is decoded ahead of the flop so the pin itself is glitch-free.
        if (w_state_nxt == STROBE) begin
            w_en_nxt = NUM_WORDS'(1) << r_idx;
        end
    end

    // Output and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_phase     <= '0;
            r_idx       <= '0;
            r_d_out     <= '0;
            r_en        <= '0;
            r_cfg_ready <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_phase     <= w_phase_nxt;
            r_idx       <= w_idx_nxt;
            r_d_out     <= w_d_out_nxt;
            r_en        <= w_en_nxt;
            r_cfg_ready <= w_cfg_ready_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
        end
    end

    assign io_cfg_ready  = r_cfg_ready;
    assign io_d_out      = r_d_out;
    assign io_configs_en = r_en;
    assign io_word_idx   = r_idx;
    assign io_busy       = r_busy;
    assign io_done       = r_done;

endmodule
